// File: rtl/fifo_stream_packer_pkg.sv
// Purpose: shared types, constants and helpers for the Fifo stream packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: show-ahead read-contract signal levels, counter width derivation,
//           lane bit-offset helper.
`timescale 1ns/1ps
package fifo_stream_packer_pkg;

  // Raw signal levels.
  localparam logic c_LO = 1'b0;
  localparam logic c_HI = 1'b1;

  // Show-ahead Fifo read contract: empty is high when nothing is at the head,
  // rdena high at a clock edge pops the head word.
  localparam logic c_FIFO_EMPTY = c_HI;
  localparam logic c_RDENA_POP  = c_HI;

  // Reset level of the read-domain reset.
  localparam logic c_RST_ACTIVE = c_LO;

  // Counter must hold 0..ratio inclusive (out_words reports a full word as ratio).
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Least significant bit of a narrow lane inside the packed word.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fifo_stream_packer_stream_out_reg.sv
// Purpose: single-entry valid/ready output register carrying packed data and word count.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds data/count while out_valid & ~out_ready; slot_free reports a load may be taken.
// Ports: clk/rst (sync, active-low); load/load_data/load_words from the packer;
//        out_valid/out_ready/out_data/out_words downstream stream; slot_free back to the packer.
`timescale 1ns/1ps
module fifo_stream_packer_stream_out_reg
  import fifo_stream_packer_pkg::*;
#(
  parameter int p_DATA_WIDTH = 32,
  parameter int p_CNT_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [p_DATA_WIDTH-1:0] load_data,
  input  logic [p_CNT_WIDTH-1:0]  load_words,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [p_DATA_WIDTH-1:0] out_data,
  output logic [p_CNT_WIDTH-1:0]  out_words,
  output logic                    slot_free
);

  // An accepted word vacates the slot in the same cycle, so a new load may
  // land on the accepting edge with no bubble.
  assign slot_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst == c_RST_ACTIVE) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_words <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_words <= load_words;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_stream_packer.sv
// Purpose: drains a show-ahead Fifo and packs p_RATIO narrow words into one wide stream word.
// Latency: output valid one cycle after the completing pop (or after the flush takes effect).
// Backpressure: pops stall only when the last lane would need a busy output slot; flush waits for a free slot.
// Ports: clk/rst (sync, active-low); empty/rddata/rdena Fifo read port; flush partial-word request;
//        out_valid/out_ready/out_data/out_words packed stream; busy activity indicator.
`timescale 1ns/1ps
module fifo_stream_packer
  import fifo_stream_packer_pkg::*;
#(
  parameter int p_WIDTH     = 8,
  parameter int p_RATIO     = 4,
  parameter int p_CNT_WIDTH = cnt_width(p_RATIO)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         empty,
  input  logic [p_WIDTH-1:0]           rddata,
  output logic                         rdena,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [p_WIDTH*p_RATIO-1:0]   out_data,
  output logic [p_CNT_WIDTH-1:0]       out_words,
  output logic                         busy
);

  localparam int                     c_OUT_W = p_WIDTH * p_RATIO;
  localparam logic [p_CNT_WIDTH-1:0] c_LAST  = p_CNT_WIDTH'(p_RATIO - 1);
  localparam logic [p_CNT_WIDTH-1:0] c_FULL  = p_CNT_WIDTH'(p_RATIO);

  logic [p_CNT_WIDTH-1:0] count, count_nxt;
  logic [c_OUT_W-1:0]     acc, acc_nxt, acc_with_head;
  logic                   flush_pend, flush_pend_nxt;
  logic                   slot_free;
  logic                   pop, pop_full, flush_emit, load;
  logic [c_OUT_W-1:0]     load_data;
  logic [p_CNT_WIDTH-1:0] load_words;

  // Accumulator with the Fifo head dropped into the lane selected by count.
  always_comb begin
    acc_with_head = acc;
    for (int i = 0; i < p_RATIO; i++) begin
      if (i == int'(count)) begin
        acc_with_head[lane_lsb(i, p_WIDTH) +: p_WIDTH] = rddata;
      end
    end
  end

  // Lanes below the last can always be filled; the last lane produces an
  // output word, so it needs the output slot to be free this cycle.
  assign pop = (rst != c_RST_ACTIVE) && (empty != c_FIFO_EMPTY) && !flush_pend &&
               ((count < c_LAST) || slot_free);
  assign rdena = pop ? c_RDENA_POP : ~c_RDENA_POP;

  assign pop_full   = pop && (count == c_LAST);
  // flush_pend blocks pops, so pop_full and flush_emit never coincide.
  assign flush_emit = flush_pend && (count != '0) && slot_free;
  assign load       = pop_full || flush_emit;
  assign load_data  = pop_full ? acc_with_head : acc;
  assign load_words = pop_full ? c_FULL : count;

  always_comb begin
    count_nxt      = count;
    acc_nxt        = acc;
    flush_pend_nxt = flush_pend;
    if (load) begin
      count_nxt = '0;
      acc_nxt   = '0;
    end else if (pop) begin
      count_nxt = count + p_CNT_WIDTH'(1);
      acc_nxt   = acc_with_head;
    end
    // A pending flush retires once the partial word is emitted, or
    // immediately if there was nothing left to emit.
    if (flush_pend) begin
      flush_pend_nxt = (count != '0) && !slot_free;
    end else begin
      flush_pend_nxt = flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == c_RST_ACTIVE) begin
      count      <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
    end else begin
      count      <= count_nxt;
      acc        <= acc_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  fifo_stream_packer_stream_out_reg #(
    .p_DATA_WIDTH (c_OUT_W),
    .p_CNT_WIDTH  (p_CNT_WIDTH)
  ) u_stream_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_words (load_words),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_words  (out_words),
    .slot_free  (slot_free)
  );

  assign busy = (count != '0) || flush_pend || out_valid;

endmodule

// File: tb/tb_fifo_stream_packer.sv
`timescale 1ns/1ps
module tb_fifo_stream_packer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int CW = 3;
  localparam int OW = W * R;

  typedef struct packed {
    logic [CW-1:0] words;
    logic [OW-1:0] data;
  } out_t;

  logic          clk = 1'b0;
  logic          uut_wr_clk = 1'b0;
  logic          rst = 1'b0;
  logic          empty = 1'b1;
  logic [W-1:0]  rddata = '0;
  logic          rdena;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_words;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  bit wr_done = 1'b0;

  logic [W-1:0] fifo_q[$];
  out_t         exp_q[$];
  out_t         got_q[$];

  fifo_stream_packer #(.p_WIDTH(W), .p_RATIO(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .rddata    (rddata),
    .rdena     (rdena),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_words (out_words),
    .busy      (busy)
  );

  always #50 clk = ~clk;
  always #33 uut_wr_clk = ~uut_wr_clk;

  // Show-ahead Fifo model: pops on rdena at the read edge, flags refresh mid-cycle.
  always @(posedge clk) begin
    if (rdena === 1'b1) begin
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow: rdena=1 while fifo empty, required rdena=0");
      end else begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    empty  = (fifo_q.size() == 0);
    rddata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  // Collect accepted words.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      got_q.push_back('{words: out_words, data: out_data});
  end

  // Held words must stay stable and valid until accepted.
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [OW-1:0] pd = '0;
  logic [CW-1:0] pw = '0;
  always @(negedge clk) begin
    if (rst === 1'b1 && pv && !pr) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== pd || out_words !== pw) begin
        errors++;
        $display("FAIL stream_hold: valid=%0b data=%h words=%0d required valid=1 data=%h words=%0d",
                 out_valid, out_data, out_words, pd, pw);
      end
    end
    pv = (rst === 1'b1) && (out_valid === 1'b1);
    pr = out_ready;
    pd = out_data;
    pw = out_words;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    ok = (got_q.size() >= n);
  endtask

  task automatic push_word_bytes(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                 input logic [W-1:0] b2, input logic [W-1:0] b3);
    fifo_q.push_back(b0); fifo_q.push_back(b1); fifo_q.push_back(b2); fifo_q.push_back(b3);
    exp_q.push_back('{words: 3'd4, data: {b3, b2, b1, b0}});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_ready = 1'b1;
    push_word_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    push_word_bytes(8'h05, 8'h06, 8'h07, 8'h08);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rdena !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
          out_data !== '0 || out_words !== '0 || pop_cnt != 0) begin
        errors++;
        $display("FAIL reset_state: cyc=%0d rdena=%b valid=%b busy=%b data=%h words=%0d pops=%0d required all 0",
                 c, rdena, out_valid, busy, out_data, out_words, pop_cnt);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rdena !== 1'b1 || pop_cnt != 0) begin
      errors++;
      $display("FAIL reset_release: rdena=%b pops=%0d required rdena=1 pops=0", rdena, pop_cnt);
    end
    tick();
    checks++;
    if (pop_cnt != 1) begin
      errors++;
      $display("FAIL first_pop: pops=%0d required 1", pop_cnt);
    end
  endtask

  task automatic test_packing();
    bit ok;
    out_t g, e;
    wait_got(2, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pack_timeout: got=%0d words required 2", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL pack_word: got data=%h words=%0d required data=%h words=%0d", g.data, g.words, e.data, e.words);
      end
    end
    repeat (4) tick();
    checks++;
    if (fifo_q.size() != 0 || pop_cnt != 8 || got_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pack_drain: fifo=%0d pops=%0d extra=%0d busy=%b required 0/8/0/0",
               fifo_q.size(), pop_cnt, got_q.size(), busy);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    out_t g, e;
    out_ready = 1'b0;
    pop_cnt = 0;
    push_word_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    push_word_bytes(8'h05, 8'h06, 8'h07, 8'h08);
    push_word_bytes(8'h09, 8'h0A, 8'h0B, 8'h0C);
    repeat (20) tick();
    checks++;
    if (pop_cnt != 7 || rdena !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: pops=%0d rdena=%b required pops=7 rdena=0", pop_cnt, rdena);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_words !== 3'd4) begin
      errors++;
      $display("FAIL bp_held: valid=%b data=%h words=%0d required 1/04030201/4", out_valid, out_data, out_words);
    end
    out_ready = 1'b1;
    wait_got(3, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_timeout: got=%0d words required 3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bp_word: got data=%h words=%0d required data=%h words=%0d", g.data, g.words, e.data, e.words);
      end
    end
    repeat (4) tick();
    checks++;
    if (got_q.size() != 0 || pop_cnt != 12 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: extra=%0d pops=%0d fifo=%0d required 0/12/0", got_q.size(), pop_cnt, fifo_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_flush();
    bit ok;
    out_t g;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    exp_q.push_back('{words: 3'd3, data: 32'h00332211});
    repeat (6) tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial_hold: valid=%b busy=%b required valid=0 busy=1", out_valid, busy);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    wait_got(1, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_timeout: got=%0d words required 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      checks++;
      if (g !== exp_q[0]) begin
        errors++;
        $display("FAIL flush_word: got data=%h words=%0d required data=%h words=%0d",
                 g.data, g.words, exp_q[0].data, exp_q[0].words);
      end
    end
    exp_q.delete();
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pend_busy: busy=%b required 1", busy);
    end
    repeat (5) tick();
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: extra=%0d busy=%b required 0 extra, busy=0", got_q.size(), busy);
    end
  endtask

  task automatic test_flush_on_full();
    bit ok;
    out_t g;
    int base;
    base = pop_cnt;
    push_word_bytes(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    tick(); tick(); tick();
    checks++;
    if (pop_cnt - base != 3) begin
      errors++;
      $display("FAIL flush_full_align: pops=%0d required 3 before flush", pop_cnt - base);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    wait_got(1, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_full_timeout: got=%0d words required 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      checks++;
      if (g !== exp_q[0]) begin
        errors++;
        $display("FAIL flush_full_word: got data=%h words=%0d required data=%h words=%0d",
                 g.data, g.words, exp_q[0].data, exp_q[0].words);
      end
    end
    exp_q.delete();
    repeat (6) tick();
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_full_extra: extra=%0d busy=%b required 0 extra, busy=0", got_q.size(), busy);
    end
  endtask

  task automatic test_concurrent();
    bit ok;
    out_t g, e;
    int n_cmp;
    logic [W-1:0] b[4];
    for (int w = 0; w < 247; w++) begin
      for (int k = 0; k < 4; k++) b[k] = W'(4 * w + k);
      exp_q.push_back('{words: 3'd4, data: {b[3], b[2], b[1], b[0]}});
    end
    b[0] = W'(988); b[1] = W'(989);
    exp_q.push_back('{words: 3'd2, data: {16'h0000, b[1], b[0]}});

    fork
      begin
        for (int k = 0; k < 990; k++) begin
          @(posedge uut_wr_clk);
          fifo_q.push_back(W'(k));
        end
        wr_done = 1'b1;
      end
    join_none

    for (int c = 0; c < 4000 && !(wr_done && fifo_q.size() == 0); c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (!(wr_done && fifo_q.size() == 0)) begin
      errors++;
      $display("FAIL conc_drain_timeout: fifo=%0d done=%0b required empty and done", fifo_q.size(), wr_done);
    end
    repeat (3) begin out_ready = 1'($urandom_range(0, 1)); tick(); end
    flush = 1'b1; tick(); flush = 1'b0;
    for (int c = 0; c < 200 && got_q.size() < 248; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    wait_got(248, 20, ok);
    repeat (5) tick();
    checks++;
    if (got_q.size() != 248) begin
      errors++;
      $display("FAIL conc_count: got=%0d words required 248", got_q.size());
    end
    n_cmp = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL conc_word[%0d]: got data=%h words=%0d required data=%h words=%0d",
                 n_cmp, g.data, g.words, e.data, e.words);
      end
      n_cmp++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_packing();
    test_backpressure();
    test_flush();
    test_flush_on_full();
    test_concurrent();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
